tdm_frame_ctrl: RTL
===================

# tdm_frame_ctrl

Frame timing controller for the serial TDM path. It runs in the serial clock domain and generates or tracks the 32-channel × 8-bit frame, producing frame_sync, channel and bit position, and per-channel strobes. These sequence the TDM input/output datapaths. It also reports frame lock and sync errors to the wishbone-side register logic.

## Interface
- NUM_CH, 32, channels per frame (2..32); frame length is NUM_CH*8 serial clocks
- LOCK_COUNT, 3, consecutive correctly placed ext_fs edges required to assert locked (slave mode)
- ERR_LIMIT, 2, consecutive missing ext_fs edges before dropping back to HUNT (slave mode)

- serial_clk  in  1  serial bit clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- enable_async  in  1  run request from system clock domain; double-flop synchronised internally
- slave_mode  in  1  0 = master (generate frame), 1 = slave (follow ext_fs); sampled only in IDLE
- ext_fs  in  1  external frame sync, used in slave mode only
- ch_mask  in  32  channel enable mask; bit n enables channel n
- frame_sync  out  1  high for the single cycle where pos == 0
- ch_num  out  5  current channel, 0..NUM_CH-1
- bit_num  out  3  current bit, 7 down to 0 (MSb first)
- ch_active  out  1  mask_q[ch_num] while in RUN, else 0
- ch_strobe  out  1  RUN & ch_active & (bit_num == 0): last bit of an enabled channel
- frame_cnt  out  16  frames started since reset; wraps
- locked  out  1  frame alignment valid
- sync_err  out  1  one-cycle pulse on misplaced or missing ext_fs
- state  out  2  IDLE = 00, HUNT = 01, RUN = 10

## Operation
- Internal slot counter pos[7:0] = ch_num*8 + (7 - bit_num). It advances by 1 per cycle in RUN and wraps from NUM_CH*8-1 to 0.
- en_s is enable_async after 2 serial_clk flops.
- Slave edge detect: fs_edge = ext_fs & ~fs_prev, with fs_prev registered every cycle in every state.
- IDLE: pos = 0; ch_num = 0; bit_num = 7; frame_sync, ch_active, ch_strobe, sync_err = 0; locked = 0.
  - en_s & ~slave_mode -> RUN with pos = 0.
  - en_s & slave_mode -> HUNT.
- HUNT:
  - fs_edge -> RUN with pos = 0; good_cnt = 1, miss_cnt = 0.
  - ~en_s -> IDLE immediately.
- RUN, master: locked = 1 throughout.
- RUN, slave, evaluated every cycle:
  - fs_edge while pos == NUM_CH*8-1: correct. Wrap to 0, miss_cnt = 0, good_cnt saturating increment; locked = 1 once good_cnt >= LOCK_COUNT.
  - fs_edge at any other pos: misaligned. Force pos = 0, pulse sync_err, locked = 0, good_cnt = 1, miss_cnt = 0.
  - Wrap from last slot with no fs_edge: missed. Pulse sync_err, miss_cnt + 1, good_cnt = 0, locked = 0. If miss_cnt reaches ERR_LIMIT, go to HUNT instead of wrapping.
- mask_q loads ch_mask on every cycle in which pos is loaded with 0, covering both entry to RUN and each wrap. The mask is therefore stable for a whole frame.
- frame_cnt increments on every load of pos = 0 in RUN. It is cleared only by reset.
- ~en_s in RUN: the current frame completes. The state goes to IDLE instead of wrapping after pos = NUM_CH*8-1, so there are no partial frames. A re-assertion of en_s before the frame ends cancels the stop.
- Simultaneous fs_edge and ~en_s at the last slot: the stop wins and the state goes to IDLE.
- Reset: asynchronous. All outputs, counters, mask_q and the synchroniser go to their IDLE values, and frame_cnt = 0.

## Timing
- All outputs are registered.
- Master start: enable_async high before edge e0 gives en_s = 1 after e1, state = RUN and frame_sync = 1 after e2.
- Slave: an ext_fs rising edge sampled at edge k produces frame_sync = 1 in the cycle after k, so outputs lag ext_fs by exactly one cycle.
- frame_sync period is NUM_CH*8 cycles. ch_num increments on the cycle after bit_num = 0.
- sync_err is asserted in the cycle following the offending edge or the missed wrap.
- Stop latency: at most NUM_CH*8 + 2 cycles from the enable_async fall to state = IDLE.

## Test plan
- Master, NUM_CH = 32, ch_mask = 0x0000_0005: raise enable. Required:
  - frame_sync is first high 2 cycles later and then every 256 cycles.
  - ch_strobe fires only at ch 0 bit 0 and ch 2 bit 0.
  - frame_cnt = 3 after three frames.
- Slave with ext_fs every 256 cycles: HUNT -> RUN on the first edge; locked rises when the 3rd consecutive correct edge is evaluated; sync_err never pulses.
- Slave locked, then ext_fs moved 5 cycles early: a sync_err pulse, locked = 0, frame_sync realigned one cycle after the new edge, relock after 3 more correct frames.
- Slave locked, then ext_fs removed: a sync_err pulse at each of 2 wraps, then state = HUNT and locked = 0; restoring ext_fs re-enters RUN.
- Master, enable dropped mid-frame at pos 100: the frame runs to pos 255 and then state = IDLE, with ch_num = 0 and bit_num = 7. Change ch_mask mid-frame: ch_active changes only at the next frame_sync.
- Assert reset mid-frame in RUN: all outputs immediately return to IDLE values, frame_cnt = 0 and locked = 0. After release with enable high, the first frame_sync comes 2 cycles later.

Source files
------------

// File: rtl/tdm_frame_ctrl.sv
// Frame timing controller for the serial TDM path.
// Generates (master) or tracks (slave) a NUM_CH x 8-bit frame and publishes
// frame_sync, channel/bit position, per-channel strobes, lock and sync errors.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stopped; position held at channel 0 bit 7, nothing asserted
// HUNT  | slave only; waiting for an ext_fs rising edge to start a frame
// RUN   | slot counter advancing; master free-runs, slave checks ext_fs
//
// The state's outputs are all registered: every output is loaded from the
// next-state values computed combinationally, so they change on the same
// edge as the internal slot counter.

module tdm_frame_ctrl #(
    parameter int NUM_CH     = 32,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_LIMIT  = 2
) (
    input  logic        serial_clk,
    input  logic        reset,
    input  logic        enable_async,
    input  logic        slave_mode,
    input  logic        ext_fs,
    input  logic [31:0] ch_mask,
    output logic        frame_sync,
    output logic [4:0]  ch_num,
    output logic [2:0]  bit_num,
    output logic        ch_active,
    output logic        ch_strobe,
    output logic [15:0] frame_cnt,
    output logic        locked,
    output logic        sync_err,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HUNT = 2'b01,
        RUN  = 2'b10
    } state_t;

    localparam logic [7:0] LAST_POS = 8'(NUM_CH * 8 - 1);
    localparam int         GW       = $clog2(LOCK_COUNT + 1);
    localparam int         EW       = $clog2(ERR_LIMIT + 1);
    localparam logic [GW-1:0] GOOD_SAT = GW'(LOCK_COUNT);
    localparam logic [EW-1:0] MISS_LIM = EW'(ERR_LIMIT);

    // registered state
    state_t        state_q;
    logic [7:0]    pos_q;
    logic [31:0]   mask_q;
    logic [GW-1:0] good_q;
    logic [EW-1:0] miss_q;
    logic          slave_q;

    // input conditioning
    logic          en_meta;
    logic          en_s;
    logic          fs_prev;
    logic          fs_edge;

    // next-state values
    state_t        nxt_state;
    logic [7:0]    nxt_pos;
    logic [31:0]   nxt_mask;
    logic [GW-1:0] nxt_good;
    logic [EW-1:0] nxt_miss;
    logic          nxt_locked;
    logic          nxt_err;
    logic          nxt_slave;
    logic          frame_start;
    logic          last_slot;
    logic [GW-1:0] good_sat;
    logic [EW-1:0] miss_inc;
    logic          nxt_run;
    logic          nxt_active;

    assign fs_edge   = ext_fs & ~fs_prev;
    assign last_slot = (pos_q == LAST_POS);
    assign good_sat  = (good_q >= GOOD_SAT) ? GOOD_SAT : good_q + GW'(1);
    assign miss_inc  = miss_q + EW'(1);
    assign state     = state_q;

    // Double-flop the run request and keep last ext_fs level for edge detection.
    always_ff @(posedge serial_clk or posedge reset) begin
        if (reset) begin
            en_meta <= 1'b0;
            en_s    <= 1'b0;
            fs_prev <= 1'b0;
        end else begin
            en_meta <= enable_async;
            en_s    <= en_meta;
            fs_prev <= ext_fs;
        end
    end

    // Next-state decision: start, wrap, realign, miss handling and stop-at-frame-end.
    always_comb begin
        nxt_state   = state_q;
        nxt_pos     = pos_q;
        nxt_mask    = mask_q;
        nxt_good    = good_q;
        nxt_miss    = miss_q;
        nxt_locked  = locked;
        nxt_err     = 1'b0;
        nxt_slave   = slave_q;
        frame_start = 1'b0;

        case (state_q)
            IDLE: begin
                nxt_pos    = '0;
                nxt_locked = 1'b0;
                if (en_s) begin
                    nxt_slave = slave_mode;
                    if (slave_mode) begin
                        nxt_state = HUNT;
                    end else begin
                        nxt_state   = RUN;
                        frame_start = 1'b1;
                        nxt_locked  = 1'b1;
                    end
                end
            end

            HUNT: begin
                nxt_pos    = '0;
                nxt_locked = 1'b0;
                if (!en_s) begin
                    nxt_state = IDLE;
                end else if (fs_edge) begin
                    nxt_state   = RUN;
                    frame_start = 1'b1;
                    nxt_good    = GW'(1);
                    nxt_miss    = '0;
                    nxt_locked  = (LOCK_COUNT <= 1);
                end
            end

            RUN: begin
                nxt_pos = pos_q + 8'd1;
                if (last_slot && !en_s) begin
                    // A pending stop takes effect only at the frame boundary,
                    // and outranks any ext_fs activity on that slot.
                    nxt_state  = IDLE;
                    nxt_pos    = '0;
                    nxt_locked = 1'b0;
                end else if (!slave_q) begin
                    if (last_slot) begin
                        frame_start = 1'b1;
                    end
                end else if (fs_edge) begin
                    frame_start = 1'b1;
                    nxt_miss    = '0;
                    if (last_slot) begin
                        nxt_good   = good_sat;
                        nxt_locked = (good_sat >= GOOD_SAT);
                    end else begin
                        nxt_err    = 1'b1;
                        nxt_locked = 1'b0;
                        nxt_good   = GW'(1);
                    end
                end else if (last_slot) begin
                    nxt_err    = 1'b1;
                    nxt_good   = '0;
                    nxt_locked = 1'b0;
                    nxt_miss   = miss_inc;
                    if (miss_inc >= MISS_LIM) begin
                        nxt_state = HUNT;
                        nxt_pos   = '0;
                    end else begin
                        frame_start = 1'b1;
                    end
                end
            end

            default: begin
                nxt_state  = IDLE;
                nxt_pos    = '0;
                nxt_locked = 1'b0;
            end
        endcase

        // Every load of slot 0 in RUN captures the mask for the whole frame.
        if (frame_start) begin
            nxt_pos  = '0;
            nxt_mask = ch_mask;
        end
    end

    assign nxt_run    = (nxt_state == RUN);
    assign nxt_active = nxt_run & nxt_mask[nxt_pos[7:3]];

    // FSM state, counters and all registered outputs.
    always_ff @(posedge serial_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pos_q      <= '0;
            mask_q     <= '0;
            good_q     <= '0;
            miss_q     <= '0;
            slave_q    <= 1'b0;
            frame_sync <= 1'b0;
            ch_num     <= '0;
            bit_num    <= 3'd7;
            ch_active  <= 1'b0;
            ch_strobe  <= 1'b0;
            frame_cnt  <= '0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state_q    <= nxt_state;
            pos_q      <= nxt_pos;
            mask_q     <= nxt_mask;
            good_q     <= nxt_good;
            miss_q     <= nxt_miss;
            slave_q    <= nxt_slave;
            frame_sync <= nxt_run & (nxt_pos == 8'd0);
            ch_num     <= nxt_pos[7:3];
            bit_num    <= ~nxt_pos[2:0];
            ch_active  <= nxt_active;
            ch_strobe  <= nxt_active & (nxt_pos[2:0] == 3'd7);
            frame_cnt  <= frame_cnt + {15'd0, frame_start};
            locked     <= nxt_locked;
            sync_err   <= nxt_err;
        end
    end

endmodule
